// File: rtl/riscv_csr_pkg.sv
// Shared CSR addresses, funct3 encodings and the read-modify-write rules
// used by the machine-mode CSR file.
package riscv_csr_pkg;

    localparam logic [11:0] CSR_TOHOST   = 12'h51E;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_WRITE,
        OP_SET,
        OP_CLEAR
    } csr_op_e;

    function automatic csr_op_e decode_op(input logic [2:0] f3);
        csr_op_e op;
        case (f3)
            F3_RW, F3_RWI: op = OP_WRITE;
            F3_RS, F3_RSI: op = OP_SET;
            F3_RC, F3_RCI: op = OP_CLEAR;
            default:       op = OP_NONE;
        endcase
        return op;
    endfunction

    // Set/clear with a zero source field (x0 or imm 0) is a pure read.
    function automatic logic op_writes(input csr_op_e op, input logic [4:0] zimm);
        logic w;
        case (op)
            OP_WRITE:         w = 1'b1;
            OP_SET, OP_CLEAR: w = (zimm != 5'd0);
            default:          w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] apply_op(input csr_op_e op,
                                             input logic [31:0] old_value,
                                             input logic [31:0] src);
        logic [31:0] result;
        case (op)
            OP_WRITE: result = src;
            OP_SET:   result = old_value | src;
            OP_CLEAR: result = old_value & ~src;
            default:  result = old_value;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/counter64.sv
// 64-bit enable counter with asynchronous active-low reset; wraps naturally.
module counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [63:0] count
);

    logic [63:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 64'd0;
        end else if (en) begin
            count_q <= count_q + 64'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// Commit-stage CSR file: tohost (R/W) plus read-only cycle and instret
// counters, with combinational read data and illegal-access detection.
module csr_file
    import riscv_csr_pkg::*;
#(
    parameter logic [31:0] RESET_TOHOST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic        stall,
    input  logic        retire,
    output logic [31:0] rd_data,
    output logic        illegal,
    output logic [31:0] csr,
    output logic        tohost_wr
);

    logic [31:0] tohost;
    logic [63:0] cycle_count;
    logic [63:0] instret_count;

    csr_op_e     op;
    logic [31:0] src;
    logic        writes;
    logic        mapped;
    logic        read_only;
    logic [31:0] old_value;
    logic [31:0] new_value;
    logic        tohost_we;
    logic        retire_en;

    assign op        = decode_op(funct3);
    assign src       = funct3[2] ? {27'b0, zimm} : rs1_data;
    assign writes    = op_writes(op, zimm);
    assign new_value = apply_op(op, old_value, src);

    always_comb begin
        mapped    = 1'b1;
        read_only = 1'b1;
        old_value = 32'h0;
        case (csr_addr)
            CSR_TOHOST: begin
                old_value = tohost;
                read_only = 1'b0;
            end
            CSR_CYCLE:    old_value = cycle_count[31:0];
            CSR_CYCLEH:   old_value = cycle_count[63:32];
            CSR_INSTRET:  old_value = instret_count[31:0];
            CSR_INSTRETH: old_value = instret_count[63:32];
            default:      mapped    = 1'b0;
        endcase
    end

    // Counters are read before this edge's increment, so a retiring csrr
    // of instret sees the count excluding itself.
    assign rd_data = (op != OP_NONE) ? old_value : 32'h0;
    assign illegal = csr_en && (op != OP_NONE) && (!mapped || (writes && read_only));

    assign tohost_we = csr_en && !stall && !illegal && writes && (csr_addr == CSR_TOHOST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tohost    <= RESET_TOHOST;
            tohost_wr <= 1'b0;
        end else begin
            tohost_wr <= tohost_we;
            if (tohost_we) begin
                tohost <= new_value;
            end
        end
    end

    assign csr       = tohost;
    assign retire_en = retire && !stall;

    counter64 u_cycle (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .count (cycle_count)
    );

    counter64 u_instret (
        .clk   (clk),
        .rst   (rst),
        .en    (retire_en),
        .count (instret_count)
    );

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: directed corner cases plus random CSR
// traffic checked against an architectural model of the three CSRs.
module tb_csr_file;

    localparam logic [31:0] RESET_TOHOST = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        csr_en;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic        stall;
    logic        retire;
    logic [31:0] rd_data;
    logic        illegal;
    logic [31:0] csr;
    logic        tohost_wr;

    typedef struct packed {
        logic [31:0] rd;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;

    logic [31:0] m_tohost;
    logic [63:0] m_cycle;
    logic [63:0] m_instret;
    logic        m_wr_exp;
    logic [63:0] force_val;

    csr_file #(.RESET_TOHOST(RESET_TOHOST)) dut (
        .clk       (clk),
        .rst       (rst),
        .csr_en    (csr_en),
        .funct3    (funct3),
        .csr_addr  (csr_addr),
        .rs1_data  (rs1_data),
        .zimm      (zimm),
        .stall     (stall),
        .retire    (retire),
        .rd_data   (rd_data),
        .illegal   (illegal),
        .csr       (csr),
        .tohost_wr (tohost_wr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h51E: return m_tohost;
            12'hC00: return m_cycle[31:0];
            12'hC80: return m_cycle[63:32];
            12'hC02: return m_instret[31:0];
            12'hC82: return m_instret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_mapped(input logic [11:0] a);
        return a inside {12'h51E, 12'hC00, 12'hC80, 12'hC02, 12'hC82};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One clock edge; the model advances the way the architecture says it should.
    task tick(input bit wr, input logic [31:0] nv);
        @(posedge clk);
        if (rst) begin
            m_cycle = m_cycle + 64'd1;
            if (retire && !stall) m_instret = m_instret + 64'd1;
            if (wr) m_tohost = nv;
            m_wr_exp = wr;
        end
        #1;
    endtask

    task idle(input bit ret, input bit stl);
        csr_en = 1'b0;
        retire = ret;
        stall  = stl;
        tick(1'b0, 32'h0);
        retire = 1'b0;
        stall  = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [2:0] f3, input logic [11:0] addr,
                                  input logic [31:0] rs1, input logic [4:0] zi,
                                  input bit ret, input bit stl);
        bit          valid, writes, ill, commit;
        logic [31:0] src, old, nv;
        exp_t        e;
        funct3   = f3;
        csr_addr = addr;
        rs1_data = rs1;
        zimm     = zi;
        retire   = ret;
        stall    = stl;
        csr_en   = 1'b1;
        valid  = (f3 != 3'd0) && (f3 != 3'd4);
        src    = f3[2] ? {27'b0, zi} : rs1;
        writes = valid && ((f3[1:0] == 2'b01) || (zi != 5'd0));
        old    = model_read(addr);
        ill    = valid && (!model_mapped(addr) || (writes && addr != 12'h51E));
        case (f3[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            default: nv = old & ~src;
        endcase
        e.rd  = valid ? old : 32'h0;
        e.ill = ill;
        exp_q.push_back(e);
        commit = !stl && !ill && writes && (addr == 12'h51E);
        tick(commit, nv);
        csr_en = 1'b0;
        retire = 1'b0;
        stall  = 1'b0;
    endtask

    task force_cycle(input logic [63:0] v);
        force_val = v;
        force dut.u_cycle.count_q = force_val;
        idle(1'b0, 1'b0);
        release dut.u_cycle.count_q;
        m_cycle = v;
    endtask

    task reset_during_write(input logic [31:0] val);
        exp_t e;
        funct3   = 3'b001;
        csr_addr = 12'h51E;
        rs1_data = val;
        zimm     = 5'd3;
        retire   = 1'b1;
        stall    = 1'b0;
        csr_en   = 1'b1;
        rst      = 1'b0;
        m_tohost  = RESET_TOHOST;
        m_cycle   = 64'd0;
        m_instret = 64'd0;
        m_wr_exp  = 1'b0;
        e.rd  = RESET_TOHOST;
        e.ill = 1'b0;
        exp_q.push_back(e);
        tick(1'b0, 32'h0);
        csr_en = 1'b0;
        retire = 1'b0;
        tick(1'b0, 32'h0);
        rst = 1'b1;
    endtask

    // Monitor: every mid-cycle, pop the expected response for an active access.
    always @(negedge clk) begin
        if (csr_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL scoreboard: got access with no expectation queued at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("rd_data", rd_data, mon_e.rd);
                check_output("illegal", {31'b0, illegal}, {31'b0, mon_e.ill});
            end
        end else begin
            check_output("illegal_idle", {31'b0, illegal}, 32'h0);
        end
        check_output("csr", csr, m_tohost);
        check_output("tohost_wr", {31'b0, tohost_wr}, {31'b0, m_wr_exp});
    end

    initial begin
        logic [31:0] r;
        logic [11:0] a;
        int          pick;
        csr_en   = 1'b0;
        funct3   = 3'd0;
        csr_addr = 12'h0;
        rs1_data = 32'h0;
        zimm     = 5'd0;
        stall    = 1'b0;
        retire   = 1'b0;
        m_tohost  = RESET_TOHOST;
        m_cycle   = 64'd0;
        m_instret = 64'd0;
        m_wr_exp  = 1'b0;
        force_val = 64'd0;
        rst = 1'b1;
        #1 rst = 1'b0;
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        rst = 1'b1;

        apply_stimulus(3'b010, 12'hC00, 32'h0, 5'd0, 1'b0, 1'b0);
        apply_stimulus(3'b010, 12'hC02, 32'h0, 5'd0, 1'b0, 1'b0);

        apply_stimulus(3'b101, 12'h51E, 32'h0, 5'd1, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        apply_stimulus(3'b001, 12'h51E, 32'h0F0, 5'd7, 1'b0, 1'b0);
        apply_stimulus(3'b011, 12'h51E, 32'h030, 5'd8, 1'b0, 1'b0);
        apply_stimulus(3'b010, 12'h51E, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        apply_stimulus(3'b001, 12'h51E, 32'h0C0, 5'd2, 1'b0, 1'b0);
        idle(1'b0, 1'b0);

        apply_stimulus(3'b001, 12'hC00, 32'h1234, 5'd4, 1'b0, 1'b0);
        apply_stimulus(3'b010, 12'hC00, 32'h0, 5'd0, 1'b0, 1'b0);
        apply_stimulus(3'b010, 12'h7C0, 32'h55, 5'd0, 1'b0, 1'b0);
        apply_stimulus(3'b110, 12'hC82, 32'h0, 5'd0, 1'b0, 1'b0);
        apply_stimulus(3'b111, 12'hC82, 32'h0, 5'd1, 1'b0, 1'b0);
        apply_stimulus(3'b000, 12'h7C0, 32'h1, 5'd1, 1'b0, 1'b0);
        apply_stimulus(3'b100, 12'h51E, 32'h9, 5'd9, 1'b0, 1'b0);
        apply_stimulus(3'b001, 12'h51E, 32'hABCD, 5'd1, 1'b0, 1'b1);
        idle(1'b0, 1'b0);

        repeat (5) idle(1'b1, 1'b1);
        apply_stimulus(3'b010, 12'hC02, 32'h0, 5'd0, 1'b1, 1'b1);
        repeat (3) idle(1'b1, 1'b0);
        apply_stimulus(3'b010, 12'hC02, 32'h0, 5'd0, 1'b1, 1'b0);
        apply_stimulus(3'b010, 12'hC02, 32'h0, 5'd0, 1'b0, 1'b0);

        force_cycle(64'h0000_0000_FFFF_FFFF);
        apply_stimulus(3'b010, 12'hC00, 32'h0, 5'd0, 1'b0, 1'b0);
        apply_stimulus(3'b010, 12'hC80, 32'h0, 5'd0, 1'b0, 1'b0);
        apply_stimulus(3'b010, 12'hC00, 32'h0, 5'd0, 1'b0, 1'b0);
        force_cycle(64'hFFFF_FFFF_FFFF_FFFF);
        apply_stimulus(3'b010, 12'hC80, 32'h0, 5'd0, 1'b0, 1'b0);
        apply_stimulus(3'b010, 12'hC00, 32'h0, 5'd0, 1'b0, 1'b0);
        apply_stimulus(3'b010, 12'hC80, 32'h0, 5'd0, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            r    = $urandom;
            pick = $urandom_range(0, 6);
            case (pick)
                0, 5:    a = 12'h51E;
                1:       a = 12'hC00;
                2:       a = 12'hC80;
                3:       a = 12'hC02;
                4:       a = 12'hC82;
                default: a = r[11:0];
            endcase
            if ($urandom_range(0, 4) == 0) begin
                idle(r[12], r[13]);
            end else begin
                apply_stimulus(r[16:14], a, $urandom,
                               (r[17:16] == 2'b00) ? 5'd0 : r[22:18],
                               r[23], (r[25:24] == 2'b00));
            end
        end

        apply_stimulus(3'b001, 12'h51E, 32'h77, 5'd1, 1'b0, 1'b0);
        reset_during_write(32'h0000_DEAD);
        idle(1'b0, 1'b0);
        apply_stimulus(3'b010, 12'hC00, 32'h0, 5'd0, 1'b0, 1'b0);
        apply_stimulus(3'b010, 12'hC02, 32'h0, 5'd0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d leftover expectations expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
